// File: rtl/multicore_pkg.sv
// Shared types for the execute-stage ALU/MDU: operation encoding and op-class helpers.
package multicore_pkg;

  localparam int DEF_DATA_SIZE = 32;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SLT    = 5'd3,
    OP_SLTU   = 5'd4,
    OP_XOR    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_OR     = 5'd8,
    OP_AND    = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } t_aluop;

  function automatic logic is_m_op(input t_aluop f);
    return f inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                     OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_base_op(input t_aluop f);
    return f inside {OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
                     OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND};
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one bit per cycle.
module mdu_iter #(
  parameter int DATA_SIZE = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_div,
  input  logic [DATA_SIZE-1:0] i_a,
  input  logic [DATA_SIZE-1:0] i_b,
  output logic                 o_done,
  output logic [DATA_SIZE-1:0] o_hi,
  output logic [DATA_SIZE-1:0] o_lo
);

  localparam int CNT_W = $clog2(DATA_SIZE);

  logic                 busy;
  logic [CNT_W-1:0]     cnt;
  logic                 div_p0;
  logic [DATA_SIZE-1:0] b_p0;
  logic [DATA_SIZE-1:0] hi_p0;
  logic [DATA_SIZE-1:0] lo_p0;
  logic [DATA_SIZE:0]   sum;
  logic [DATA_SIZE:0]   shifted;
  logic [DATA_SIZE:0]   diff;
  logic [DATA_SIZE-1:0] hi_nxt;
  logic [DATA_SIZE-1:0] lo_nxt;

  // Multiply keeps the multiplier in lo and shifts the product in from the top;
  // divide shifts the dividend out of lo into the partial remainder in hi.
  always_comb begin
    sum     = {1'b0, hi_p0} + (lo_p0[0] ? {1'b0, b_p0} : '0);
    shifted = {hi_p0, lo_p0[DATA_SIZE-1]};
    diff    = shifted - {1'b0, b_p0};
    if (div_p0) begin
      hi_nxt = diff[DATA_SIZE] ? shifted[DATA_SIZE-1:0] : diff[DATA_SIZE-1:0];
      lo_nxt = {lo_p0[DATA_SIZE-2:0], ~diff[DATA_SIZE]};
    end else begin
      hi_nxt = sum[DATA_SIZE:1];
      lo_nxt = {sum[0], lo_p0[DATA_SIZE-1:1]};
    end
  end

  assign o_done = busy && (cnt == CNT_W'(DATA_SIZE - 1));
  assign o_hi   = hi_p0;
  assign o_lo   = lo_p0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (i_start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      if (o_done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_start) begin
      div_p0 <= i_div;
      b_p0   <= i_b;
      hi_p0  <= '0;
      lo_p0  <= i_a;
    end else if (busy) begin
      hi_p0 <= hi_nxt;
      lo_p0 <= lo_nxt;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with optional iterative M-extension unit behind valid/ready.
// Define ALU_MDU_M_EN to build multiply/divide; otherwise M ops report illegal.
module alu_mdu
  import multicore_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int TAG_W     = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  t_aluop               i_funct,
  input  logic [DATA_SIZE-1:0] i_op_a,
  input  logic [DATA_SIZE-1:0] i_op_b,
  input  logic [TAG_W-1:0]     i_tag,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [DATA_SIZE-1:0] o_result,
  output logic [TAG_W-1:0]     o_tag,
  output logic                 o_illegal
);

  localparam int SH_W = $clog2(DATA_SIZE);

`ifdef ALU_MDU_M_EN
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
  localparam logic [DATA_SIZE-1:0] MIN_VAL = {1'b1, {(DATA_SIZE-1){1'b0}}};
  localparam logic [DATA_SIZE-1:0] ONES    = '1;
`else
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

  state_t               state;
  state_t               state_nxt;
  state_t               acc_state;
  logic                 accept;
  logic                 legal;
  logic [DATA_SIZE-1:0] imm_result;

  function automatic logic [DATA_SIZE-1:0] base_op(input t_aluop f,
                                                   input logic [DATA_SIZE-1:0] a,
                                                   input logic [DATA_SIZE-1:0] b);
    logic signed [DATA_SIZE-1:0] sa;
    logic signed [DATA_SIZE-1:0] sb;
    logic        [SH_W-1:0]      sh;
    logic        [DATA_SIZE-1:0] r;
    sa = a;
    sb = b;
    sh = b[SH_W-1:0];
    case (f)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = $unsigned(sa >>> sh);
      OP_SLT:  r = {{(DATA_SIZE-1){1'b0}}, sa < sb};
      OP_SLTU: r = {{(DATA_SIZE-1){1'b0}}, a < b};
      OP_XOR:  r = a ^ b;
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      default: r = '0;
    endcase
    return r;
  endfunction

`ifdef ALU_MDU_M_EN
  logic                     is_m;
  logic                     is_div;
  logic                     is_rem;
  logic                     div0;
  logic                     ovf;
  logic                     a_sgn;
  logic                     b_sgn;
  logic                     go_iter;
  logic [DATA_SIZE-1:0]     a_mag;
  logic [DATA_SIZE-1:0]     b_mag;
  t_aluop                   op_p1;
  logic                     neg_p1;
  logic                     rneg_p1;
  logic                     mdu_done;
  logic [DATA_SIZE-1:0]     mdu_hi;
  logic [DATA_SIZE-1:0]     mdu_lo;
  logic [2*DATA_SIZE-1:0]   prod;
  logic [2*DATA_SIZE-1:0]   prod_s;
  logic [DATA_SIZE-1:0]     fix_result;

  // Accept stage: classify, catch divide fast paths, form operand magnitudes
  always_comb begin
    is_m   = is_m_op(i_funct);
    is_div = i_funct inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    is_rem = i_funct inside {OP_REM, OP_REMU};
    div0   = is_div && (i_op_b == '0);
    ovf    = (i_funct inside {OP_DIV, OP_REM}) && (i_op_a == MIN_VAL) && (i_op_b == ONES);
    a_sgn  = (i_funct inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && i_op_a[DATA_SIZE-1];
    b_sgn  = (i_funct inside {OP_MULH, OP_DIV, OP_REM}) && i_op_b[DATA_SIZE-1];
    a_mag  = a_sgn ? -i_op_a : i_op_a;
    b_mag  = b_sgn ? -i_op_b : i_op_b;
    legal  = is_base_op(i_funct) || is_m;
    go_iter = is_m && !div0 && !ovf;
    acc_state = go_iter ? ITER : DONE;
    if (!legal)
      imm_result = '0;
    else if (!is_m)
      imm_result = base_op(i_funct, i_op_a, i_op_b);
    else if (div0)
      imm_result = is_rem ? i_op_a : ONES;
    else
      imm_result = is_rem ? '0 : MIN_VAL;
  end

  mdu_iter #(.DATA_SIZE(DATA_SIZE)) u_mdu_iter (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (accept && go_iter),
    .i_div   (is_div),
    .i_a     (a_mag),
    .i_b     (b_mag),
    .o_done  (mdu_done),
    .o_hi    (mdu_hi),
    .o_lo    (mdu_lo)
  );

  always_ff @(posedge i_clk) begin
    if (accept) begin
      op_p1   <= i_funct;
      neg_p1  <= a_sgn ^ b_sgn;
      rneg_p1 <= a_sgn;
    end
  end

  // Fix stage: restore signs and pick the requested half / quotient / remainder
  always_comb begin
    prod   = {mdu_hi, mdu_lo};
    prod_s = neg_p1 ? -prod : prod;
    case (op_p1)
      OP_MUL:                       fix_result = prod_s[DATA_SIZE-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_s[2*DATA_SIZE-1:DATA_SIZE];
      OP_DIV, OP_DIVU:              fix_result = neg_p1 ? -mdu_lo : mdu_lo;
      OP_REM, OP_REMU:              fix_result = rneg_p1 ? -mdu_hi : mdu_hi;
      default:                      fix_result = '0;
    endcase
  end
`else
  always_comb begin
    legal      = is_base_op(i_funct);
    acc_state  = DONE;
    imm_result = legal ? base_op(i_funct, i_op_a, i_op_b) : '0;
  end
`endif

  assign accept = i_valid && o_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = acc_state;
`ifdef ALU_MDU_M_EN
      ITER: if (mdu_done) state_nxt = FIX;
      FIX:  state_nxt = DONE;
`endif
      DONE: if (i_ready) state_nxt = accept ? acc_state : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_valid = (state == DONE);
    o_ready = (state == IDLE) || ((state == DONE) && i_ready);
  end

  // Result stage: single-cycle results land on accept, iterative ones leaving FIX
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_result  <= '0;
      o_tag     <= '0;
      o_illegal <= 1'b0;
    end else if (accept) begin
      o_tag     <= i_tag;
      o_illegal <= !legal;
      o_result  <= imm_result;
    end
`ifdef ALU_MDU_M_EN
    else if (state == FIX) begin
      o_result <= fix_result;
    end
`endif
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: directed corner cases plus randomized traffic
// with backpressure; adapts its reference model to the ALU_MDU_M_EN build option.
module tb_alu_mdu;
  import multicore_pkg::*;

  localparam logic [31:0] MINV = 32'h8000_0000;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  t_aluop      i_funct;
  logic [31:0] i_op_a;
  logic [31:0] i_op_b;
  logic [3:0]  i_tag;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic [3:0]  o_tag;
  logic        o_illegal;

  alu_mdu #(.DATA_SIZE(32), .TAG_W(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_funct(i_funct), .i_op_a(i_op_a), .i_op_b(i_op_b), .i_tag(i_tag),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
    .o_tag(o_tag), .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   vld_cyc = 0;
  bit   new_res = 1'b1;
  bit   bp_en = 1'b0;
  bit   rdy_force = 1'b1;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(posedge i_clk) begin
    #1;
    i_ready = bp_en ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference semantics straight from the ISA definitions, using wide arithmetic.
  function automatic void model(input t_aluop f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill, output int lat);
    logic signed [31:0] sa, sb;
    logic signed [63:0] ea, eb, p;
    logic [63:0]        pu;
    logic [4:0]         sh;
    sa = a; sb = b; ea = sa; eb = sb; sh = b[4:0];
    r = '0; ill = 1'b0; lat = 1;
    case (f)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = sa >>> sh;
      OP_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      OP_XOR:  r = a ^ b;
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
`ifdef ALU_MDU_M_EN
      OP_MUL:    begin p = ea * eb; r = p[31:0]; lat = 34; end
      OP_MULH:   begin p = ea * eb; r = p[63:32]; lat = 34; end
      OP_MULHSU: begin p = ea * $signed({32'd0, b}); r = p[63:32]; lat = 34; end
      OP_MULHU:  begin pu = {32'd0, a} * {32'd0, b}; r = pu[63:32]; lat = 34; end
      OP_DIV:
        if (b == 0) r = '1;
        else if (a == MINV && b == '1) r = MINV;
        else begin r = sa / sb; lat = 34; end
      OP_REM:
        if (b == 0) r = a;
        else if (a == MINV && b == '1) r = '0;
        else begin r = sa % sb; lat = 34; end
      OP_DIVU: if (b == 0) r = '1; else begin r = a / b; lat = 34; end
      OP_REMU: if (b == 0) r = a;  else begin r = a % b; lat = 34; end
`endif
      default: begin ill = 1'b1; r = '0; end
    endcase
  endfunction

  task automatic issue(input t_aluop f, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag);
    exp_t e;
    int   n;
    i_valid = 1'b1; i_funct = f; i_op_a = a; i_op_b = b; i_tag = tag;
    n = 0;
    @(negedge i_clk);
    while (!o_ready && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_ready) begin
      chk("accept_timeout", 64'(o_ready), 64'd1);
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      return;
    end
    @(posedge i_clk); #1;
    model(f, a, b, e.res, e.ill, e.lat);
    e.tag = tag;
    e.acc = cyc - 1;
    q.push_back(e);
    i_valid = 1'b0;
    i_funct = t_aluop'(5'($urandom_range(0, 31)));
    i_op_a  = $urandom;
    i_op_b  = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 500) begin
      @(negedge i_clk);
      n++;
    end
    chk("drain_pending", 64'(q.size()), 64'd0);
    @(posedge i_clk); #1;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return MINV;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops the scoreboard when a result is taken, checks holds and busy ready.
  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst) begin
      new_res = 1'b1;
    end else begin
      if (o_valid && new_res) begin
        vld_cyc = cyc;
        new_res = 1'b0;
      end
      if (o_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 64'(o_valid), 64'd0);
          new_res = 1'b1;
        end else if (i_ready) begin
          e = q.pop_front();
          chk("result",  64'(o_result),      64'(e.res));
          chk("tag",     64'(o_tag),         64'(e.tag));
          chk("illegal", 64'(o_illegal),     64'(e.ill));
          chk("latency", 64'(vld_cyc - e.acc), 64'(e.lat));
          new_res = 1'b1;
        end else begin
          chk("hold_result", 64'(o_result), 64'(q[0].res));
          chk("hold_tag",    64'(o_tag),    64'(q[0].tag));
          chk("hold_ready",  64'(o_ready),  64'd0);
        end
      end else if (q.size() > 0) begin
        chk("busy_ready", 64'(o_ready), 64'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int seen;
    i_rst = 1'b1; i_valid = 1'b0; i_funct = OP_ADD; i_op_a = '0; i_op_b = '0; i_tag = '0;
    i_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_valid",   64'(o_valid),   64'd0);
    chk("rst_ready",   64'(o_ready),   64'd1);
    chk("rst_result",  64'(o_result),  64'd0);
    chk("rst_tag",     64'(o_tag),     64'd0);
    chk("rst_illegal", 64'(o_illegal), 64'd0);
    @(posedge i_clk); #1;

    issue(OP_ADD, 32'h7FFF_FFFF, 32'd1, 4'd3);
    c0 = cyc;
    for (int i = 0; i < 5; i++) issue(OP_ADD, $urandom, $urandom, 4'(i));
    chk("b2b_cycles", 64'(cyc - c0), 64'd5);
    drain();

    issue(OP_SRA,  MINV,           32'h21,         4'd1);
    issue(OP_SLTU, 32'd1,          32'hFFFF_FFFF,  4'd2);
    issue(OP_SLT,  32'd1,          32'hFFFF_FFFF,  4'd3);
    issue(OP_MULH, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  4'd4);
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  4'd5);
    issue(OP_DIV,  32'hFFFF_FFF9,  32'd2,          4'd6);
    issue(OP_REM,  32'hFFFF_FFF9,  32'd2,          4'd7);
    issue(OP_DIVU, 32'd5,          32'd0,          4'd8);
    issue(OP_DIV,  MINV,           32'hFFFF_FFFF,  4'd9);
    issue(OP_REM,  MINV,           32'hFFFF_FFFF,  4'd10);
    issue(OP_MUL,  32'd3,          32'd4,          4'd11);
    issue(t_aluop'(5'd25), 32'd7,  32'd9,          4'd12);
    drain();

    // Backpressure hold, then release
    rdy_force = 1'b0;
    issue(OP_XOR, 32'hA5A5_0F0F, 32'h0FF0_FFFF, 4'd13);
    repeat (5) @(posedge i_clk);
    #1 rdy_force = 1'b1;
    drain();

    // Reset while an operation is in flight
    rdy_force = 1'b0;
    issue(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 4'd9);
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b1;
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    q.delete();
    rdy_force = 1'b1;
    @(negedge i_clk);
    chk("midrst_ready",  64'(o_ready),  64'd1);
    chk("midrst_tag",    64'(o_tag),    64'd0);
    chk("midrst_result", 64'(o_result), 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge i_clk);
      if (o_valid) seen++;
    end
    chk("midrst_no_valid", 64'(seen), 64'd0);
    @(posedge i_clk); #1;

    bp_en = 1'b1;
    for (int i = 0; i < 150; i++)
      issue(t_aluop'(5'($urandom_range(0, 19))), rnd_op(), rnd_op(), 4'($urandom));
    bp_en = 1'b0;
    rdy_force = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Multi-cycle, parametrised execution unit succeeding the combinational ALU in each core's execute stage. It computes all RV32I register/immediate ALU operations in one registered cycle and, when compiled in, the RISC-V M-extension multiply/divide operations iteratively. Operands enter and results leave through valid/ready handshakes with a pass-through tag, so the core issue logic can stall on long operations.

## Interface
- DATA_SIZE, 32: operand/result width; power of two, ≥8.
- TAG_W, 4: width of the opaque tag carried from request to result.

- i_clk  in  1  clock, all state on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  request valid.
- o_ready  out  1  unit can accept a request this cycle.
- i_funct  in  t_aluop  operation select.
- i_op_a, i_op_b  in  DATA_SIZE  operands (two's complement).
- i_tag  in  TAG_W  request tag.
- o_valid  out  1  result valid; held until taken.
- i_ready  in  1  consumer takes result this cycle.
- o_result  out  DATA_SIZE  result.
- o_tag  out  TAG_W  tag of the request producing o_result.
- o_illegal  out  1  funct not supported in this build; o_result = 0.

## Operation
- Request accepted on i_valid && o_ready; result taken on o_valid && i_ready.
- States: IDLE, ITER, FIX, DONE.
  - IDLE: o_ready=1. Accept base op, illegal op, or M-op fast path → DONE. Accept other M-op → ITER, iteration counter = 0.
  - ITER: one bit per cycle (shift-add multiply on operand magnitudes; restoring divide on magnitudes); exactly DATA_SIZE cycles, then FIX.
  - FIX: apply sign correction and select high/low half or quotient/remainder; → DONE.
  - DONE: o_valid=1. On i_ready: with a new accept the same cycle, take its path (throughput 1 for base ops); else → IDLE.
- o_ready = (state==IDLE) || (state==DONE && i_ready). Low in ITER/FIX.
- Base ops: ADD, SUB wrap modulo 2^DATA_SIZE; SLL/SRL/SRA use only op_b[$clog2(DATA_SIZE)-1:0]; SLT signed, SLTU unsigned, zero-extended 0/1; XOR/OR/AND bitwise.
- M ops: MUL low half; MULH s×s high; MULHSU s×u high; MULHU u×u high; DIV/REM signed (truncate toward zero, remainder has dividend's sign); DIVU/REMU unsigned.
- Fast paths (no ITER): divisor 0 → quotient all-ones, remainder = op_a; signed DIV/REM with op_a=MIN, op_b=−1 → quotient MIN, remainder 0.
- Unknown funct: o_illegal=1, o_result=0, normal 1-cycle latency.
- o_result/o_tag/o_illegal stable while o_valid && !i_ready.

## Timing
- Reset: state IDLE, o_valid=0, o_ready=1 in following cycle, o_result=0, o_tag=0, o_illegal=0, counter 0.
- Base op/fast path accepted edge N → o_valid from cycle N+1.
- Iterative M-op accepted edge N → o_valid from cycle N+DATA_SIZE+2.
- i_rst mid-ITER/FIX/DONE: operation and pending result discarded, no o_valid.
- Inputs ignored whenever o_ready=0; i_funct/operands sampled only on accept.

## Configuration
- ALU_MDU_M_EN defined: M ops and ITER/FIX datapath built as above.
- Undefined: no multiply/divide hardware, FSM reduces to IDLE/DONE; all M funct values treated as unknown (o_illegal=1, result 0, latency 1).

## Structure
- multicore_pkg: DATA_SIZE default, t_aluop enum extended with MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU; helper function is_m_op().
- Local FSM state enum stays in the module.
- One sub-module: mdu_iter (iterative multiply/divide core with start/done), instantiated only under ALU_MDU_M_EN.

## Test plan
- ADD 0x7FFFFFFF+1 tag 3, i_ready=1 → o_valid next cycle, 0x80000000, o_tag 3; back-to-back ADDs every cycle → one result per cycle.
- SRA 0x80000000 by op_b=0x21 → shift 1, result 0xC0000000; SLTU 1 vs 0xFFFFFFFF → 1; SLT same → 0.
- MULH 0xFFFFFFFF×0xFFFFFFFF → 0x0; MULHU same → 0xFFFFFFFE; o_valid exactly 34 cycles after accept, o_ready low throughout.
- DIV −7/2 → 0xFFFFFFFD, REM → 0xFFFFFFFF; DIVU 5/0 → 0xFFFFFFFF after 1 cycle; DIV 0x80000000/−1 → 0x80000000, REM → 0.
- Hold i_ready=0 for 5 cycles after result → outputs stable, o_ready=0; assert i_rst during ITER → no o_valid, o_ready=1 after reset.
- Build without ALU_MDU_M_EN: MUL 3×4 → o_illegal=1, o_result=0, latency 1.
